ebn: RTL

//  Parametrised N-entry elastic buffer: the generalised successor of the 2-entry valid/ready stage.

---
 rtl/ebn.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ebn.sv
// ebn: parametrised N-entry elastic buffer with fill level, almost-full flag and synchronous flush.
// Optional zero-latency pass-through when empty is enabled by defining EBN_BYPASS_EN.

module ebn_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Storage is deliberately not reset; valid-ness lives in the count register.
  always_ff @(posedge clk)
    if (we) q <= d;
endmodule

module ebn #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] t0_data,
  input  logic             t0_valid,
  output logic             t0_ready,
  output logic [WIDTH-1:0] i0_data,
  output logic             i0_valid,
  input  logic             i0_ready,
  output logic [AW:0]      fill,
  output logic             t0_afull
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_LVL);

  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic [AW:0]                   count, count_nxt;
  logic                          t0_ready_q;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_q;
  logic [DEPTH-1:0]              ent_we;
  logic                          empty, push, pop, byp_act, byp_take;
  logic                          mem_push, mem_pop;

  assign empty = (count == '0);

`ifdef EBN_BYPASS_EN
  // Pass-through is gated by t0_ready so a beat is never offered downstream
  // unless upstream sees it accepted in the same cycle.
  assign byp_act = empty & ~flush & t0_ready_q;
`else
  assign byp_act = 1'b0;
`endif

  always_comb begin
    i0_valid = 1'b0;
    if (!flush) begin
      if (!empty)       i0_valid = 1'b1;
      else if (byp_act) i0_valid = t0_valid;
    end
  end

  assign i0_data = byp_act ? t0_data : mem_q[rd_ptr];

  assign push     = t0_valid & t0_ready_q & ~flush;
  assign pop      = i0_valid & i0_ready;
  // A beat that goes straight through is neither stored nor counted.
  assign byp_take = byp_act & push & pop;
  assign mem_push = push & ~byp_take;
  assign mem_pop  = pop  & ~byp_take;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else begin
      case ({mem_push, mem_pop})
        2'b10:   count_nxt = count + (AW+1)'(1);
        2'b01:   count_nxt = count - (AW+1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      t0_ready_q <= 1'b0;
    end else begin
      count      <= count_nxt;
      // Registered ready: a same-cycle pop at full cannot reopen the input.
      t0_ready_q <= (count_nxt < DEPTH_C) & ~flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (mem_push) wr_ptr <= wr_ptr + AW'(1);
        if (mem_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_we[g] = mem_push & (wr_ptr == AW'(g));
    ebn_entry #(.WIDTH(WIDTH)) u_ent (
      .clk (clk),
      .we  (ent_we[g]),
      .d   (t0_data),
      .q   (mem_q[g])
    );
  end

  assign t0_ready = t0_ready_q;
  assign fill     = count;
  assign t0_afull = (count >= AFULL_C);

endmodule
